// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin arbiter and two-step sequencer for one shared ULA.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   pN_req_valid/ready      request handshake (N = 0, 1); ready is combinational
//   pN_a, pN_b, pN_op       operands and opcode, latched at acceptance
//   pN_rsp_valid/ready      response handshake, valid held until ready
//   pN_rsp_data/flag/err    registered ULA result, flag, illegal-opcode error
//   alu_a, alu_b, alu_opcode  drives to the ULA
//   alu_out, alu_flag       results from the ULA
//   busy                    high whenever the sequencer is not idle
module ula_arbiter #(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OP_W = 5,
  parameter logic [OP_W-1:0] NOP_OP = 5'b00010
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [DATA_W-1:0] p0_a,
  input  logic [DATA_W-1:0] p0_b,
  input  logic [OP_W-1:0]   p0_op,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_rsp_data,
  output logic              p0_rsp_flag,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [DATA_W-1:0] p1_a,
  input  logic [DATA_W-1:0] p1_b,
  input  logic [OP_W-1:0]   p1_op,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_rsp_data,
  output logic              p1_rsp_flag,
  output logic              p1_rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_flag,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_ERR   = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic              last_grant;
  logic              owner;
  logic [OP_W-1:0]   op_q;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              owner_rsp_ready;

  logic              rsp_valid_q [2];
  logic [DATA_W-1:0] rsp_data_q  [2];
  logic              rsp_flag_q  [2];
  logic              rsp_err_q   [2];

  // Opcodes the ULA implements; everything else is answered with rsp_err.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic legal;
    legal = 1'b1;
    if (op == 5'b00010 || op == 5'b00111) legal = 1'b0;
    if (op >= 5'b01010 && op <= 5'b01111) legal = 1'b0;
    return legal;
  endfunction

  // Arbitration and next-state logic.
  always_comb begin
    state_next      = state;
    grant0          = 1'b0;
    grant1          = 1'b0;
    owner_rsp_ready = owner ? p1_rsp_ready : p0_rsp_ready;
    if (state == S_IDLE && !reset) begin
      // With both requesting, the port that did not win last time goes first.
      grant0 = p0_req_valid && (!p1_req_valid || last_grant);
      grant1 = p1_req_valid && (!p0_req_valid || !last_grant);
    end
    accept = grant0 || grant1;
    sel_op = grant1 ? p1_op : p0_op;
    sel_a  = grant1 ? p1_a  : p0_a;
    sel_b  = grant1 ? p1_b  : p0_b;
    case (state)
      S_IDLE:  if (accept) state_next = op_legal(sel_op) ? S_SETUP : S_ERR;
      S_SETUP: state_next = S_EXEC;
      S_EXEC:  state_next = S_RESP;
      S_ERR:   state_next = S_RESP;
      S_RESP:  if (owner_rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Request latch, ULA drive sequencing and per-port response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= NOP_OP;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= NOP_OP;
      busy       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rsp_valid_q[i] <= 1'b0;
        rsp_data_q[i]  <= '0;
        rsp_flag_q[i]  <= 1'b0;
        rsp_err_q[i]   <= 1'b0;
      end
    end else begin
      busy <= (state_next != S_IDLE);
      if (accept) begin
        last_grant <= grant1;
        owner      <= grant1;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        op_q       <= sel_op;
      end
      case (state)
        // The opcode change from NOP_OP is what makes the ULA evaluate.
        S_SETUP: alu_opcode <= op_q;
        S_EXEC: begin
          alu_opcode          <= NOP_OP;
          rsp_data_q[owner]   <= alu_out;
          rsp_flag_q[owner]   <= alu_flag;
          rsp_err_q[owner]    <= 1'b0;
          rsp_valid_q[owner]  <= 1'b1;
        end
        S_ERR: begin
          rsp_data_q[owner]   <= '0;
          rsp_flag_q[owner]   <= 1'b0;
          rsp_err_q[owner]    <= 1'b1;
          rsp_valid_q[owner]  <= 1'b1;
        end
        S_RESP: if (owner_rsp_ready) rsp_valid_q[owner] <= 1'b0;
        default: ;
      endcase
    end
  end

  assign p0_req_ready = grant0;
  assign p1_req_ready = grant1;
  assign p0_rsp_valid = rsp_valid_q[0];
  assign p0_rsp_data  = rsp_data_q[0];
  assign p0_rsp_flag  = rsp_flag_q[0];
  assign p0_rsp_err   = rsp_err_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p1_rsp_data  = rsp_data_q[1];
  assign p1_rsp_flag  = rsp_flag_q[1];
  assign p1_rsp_err   = rsp_err_q[1];

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter with a behavioural ULA attached.
module tb_ula_arbiter;

  localparam logic [4:0] NOP = 5'b00010;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic        p0_req_ready, p1_req_ready;
  logic [31:0] p0_a = '0, p0_b = '0, p1_a = '0, p1_b = '0;
  logic [4:0]  p0_op = '0, p1_op = '0;
  logic        p0_rsp_valid, p1_rsp_valid;
  logic        p0_rsp_ready = 1'b1, p1_rsp_ready = 1'b1;
  logic [31:0] p0_rsp_data, p1_rsp_data;
  logic        p0_rsp_flag, p1_rsp_flag, p0_rsp_err, p1_rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic [31:0] ula_out = '0;
  logic        ula_flag = 1'b0;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  ula_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_a(p0_a), .p0_b(p0_b), .p0_op(p0_op),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_data(p0_rsp_data), .p0_rsp_flag(p0_rsp_flag), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_a(p1_a), .p1_b(p1_b), .p1_op(p1_op),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_data(p1_rsp_data), .p1_rsp_flag(p1_rsp_flag), .p1_rsp_err(p1_rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(ula_out), .alu_flag(ula_flag), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural ULA: {flag, out}; carry/borrow for arithmetic, zero flag otherwise.
  function automatic logic [32:0] ula_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    case (op)
      5'b00000: r = {1'b0, a} + {1'b0, b};
      5'b00001: r = {(a & b) == 32'd0, a & b};
      5'b00011: r = {1'b0, a} + 33'd1;
      5'b00100: r = {(a | b) == 32'd0, a | b};
      5'b00101: r = {a < b, a - b};
      5'b00110: r = {(a ^ b) == 32'd0, a ^ b};
      5'b01000: r = {a == 32'hFFFF_FFFF, ~a};
      5'b01001: r = {a[31], a << 1};
      default:  r = {a == 32'd0, a};
    endcase
    return r;
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return op inside {5'd2, 5'd7, [5'd10:5'd15]};
  endfunction

  // The ULA only re-evaluates when its opcode changes, and holds on NOP.
  always @(alu_opcode) begin
    if (alu_opcode != NOP) {ula_flag, ula_out} = ula_f(alu_opcode, alu_a, alu_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic req_rdy(input logic p);
    return p ? p1_req_ready : p0_req_ready;
  endfunction
  function automatic logic rsp_v(input logic p);
    return p ? p1_rsp_valid : p0_rsp_valid;
  endfunction
  function automatic logic [31:0] rsp_d(input logic p);
    return p ? p1_rsp_data : p0_rsp_data;
  endfunction
  function automatic logic rsp_f(input logic p);
    return p ? p1_rsp_flag : p0_rsp_flag;
  endfunction
  function automatic logic rsp_e(input logic p);
    return p ? p1_rsp_err : p0_rsp_err;
  endfunction

  task automatic drive_req(input logic p, input logic v, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (p) begin p1_req_valid = v; p1_op = op; p1_a = a; p1_b = b; end
    else   begin p0_req_valid = v; p0_op = op; p0_a = a; p0_b = b; end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        f;
    logic        e;
  } vec_t;

  vec_t vecs [8];

  // One operation with rsp_ready high; checks the cycle-by-cycle ULA drive.
  task automatic run_vec(input vec_t v);
    drive_req(v.port, 1'b1, v.op, v.a, v.b);
    @(negedge clock);
    check1("t0_req_ready", req_rdy(v.port), 1'b1);
    check1("t0_other_ready", req_rdy(!v.port), 1'b0);
    next_cycle();
    drive_req(v.port, 1'b0, 5'($urandom), $urandom, $urandom);
    @(negedge clock);
    check("t1_opcode", 32'(alu_opcode), 32'(NOP));
    check1("t1_busy", busy, 1'b1);
    if (!v.e) check("t1_alu_a", alu_a, v.a);
    next_cycle();
    @(negedge clock);
    if (v.e) begin
      check("t2_opcode_err", 32'(alu_opcode), 32'(NOP));
      check1("t2_err_valid", rsp_v(v.port), 1'b1);
      check1("t2_err_flag", rsp_e(v.port), 1'b1);
      check("t2_err_data", rsp_d(v.port), 32'd0);
    end else begin
      check("t2_opcode", 32'(alu_opcode), 32'(v.op));
      check1("t2_no_valid", rsp_v(v.port), 1'b0);
      next_cycle();
      @(negedge clock);
      check1("t3_valid", rsp_v(v.port), 1'b1);
      check("t3_data", rsp_d(v.port), v.d);
      check1("t3_flag", rsp_f(v.port), v.f);
      check1("t3_err", rsp_e(v.port), 1'b0);
      check("t3_opcode", 32'(alu_opcode), 32'(NOP));
    end
    check1("other_no_rsp", rsp_v(!v.port), 1'b0);
    next_cycle();
  endtask

  // Reference model state for the random phase.
  logic        m_busy, m_lg, m_own, m_flag, m_err, g0, g1;
  logic [31:0] m_data;
  int          m_cnt, m_lat;
  logic        acc [2];

  initial begin
    vecs[0] = '{1'b0, 5'b00000, 32'd5,          32'd7,  32'd12,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 5'b00101, 32'd10,         32'd3,  32'd7,          1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'b00101, 32'd3,          32'd10, 32'hFFFF_FFF9,  1'b1, 1'b0};
    vecs[3] = '{1'b0, 5'b00011, 32'hFFFF_FFFF,  32'd0,  32'd0,          1'b1, 1'b0};
    vecs[4] = '{1'b0, 5'b00011, 32'd1,          32'd0,  32'd2,          1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'b01011, 32'd9,          32'd9,  32'd0,          1'b0, 1'b1};
    vecs[6] = '{1'b0, 5'b10101, 32'hA5A5_A5A5,  32'd1,  32'hA5A5_A5A5,  1'b0, 1'b0};
    vecs[7] = '{1'b0, 5'b00111, 32'd4,          32'd4,  32'd0,          1'b0, 1'b1};

    // Reset values.
    next_cycle();
    @(negedge clock);
    check1("rst_p0_req_ready", p0_req_ready, 1'b0);
    check1("rst_p1_rsp_valid", p1_rsp_valid, 1'b0);
    check1("rst_p0_rsp_valid", p0_rsp_valid, 1'b0);
    check("rst_opcode", 32'(alu_opcode), 32'(NOP));
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_p0_data", p0_rsp_data, 32'd0);
    check1("rst_busy", busy, 1'b0);
    reset_dut();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention: both ports requesting SUB every cycle, alternating grants.
    reset_dut();
    drive_req(1'b0, 1'b1, 5'b00101, 32'd10, 32'd3);
    drive_req(1'b1, 1'b1, 5'b00101, 32'd3, 32'd10);
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      check1("rr_ready0", p0_req_ready, (c % 4 == 0) && ((c / 4) % 2 == 0));
      check1("rr_ready1", p1_req_ready, (c % 4 == 0) && ((c / 4) % 2 == 1));
      check1("rr_valid0", p0_rsp_valid, (c % 4 == 3) && ((c / 4) % 2 == 0));
      check1("rr_valid1", p1_rsp_valid, (c % 4 == 3) && ((c / 4) % 2 == 1));
      if (c % 4 == 3 && (c / 4) % 2 == 0) check("rr_data0", p0_rsp_data, 32'd7);
      if (c % 4 == 3 && (c / 4) % 2 == 1) check("rr_data1", p1_rsp_data, 32'hFFFF_FFF9);
      next_cycle();
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;

    // Back-pressure: p0 response held 5 cycles, p1 stalls then wins.
    reset_dut();
    p0_rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 5'b10101, 32'hA5A5_A5A5, 32'd0);
    @(negedge clock);
    check1("bp_p0_ready", p0_req_ready, 1'b1);
    next_cycle();
    p0_req_valid = 1'b0;
    drive_req(1'b1, 1'b1, 5'b00000, 32'd1, 32'd2);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clock);
      check1("bp_p1_stall", p1_req_ready, 1'b0);
      if (t >= 3) begin
        check1("bp_p0_valid", p0_rsp_valid, 1'b1);
        check("bp_p0_data", p0_rsp_data, 32'hA5A5_A5A5);
      end
      next_cycle();
      if (t == 7) p0_rsp_ready = 1'b1;
    end
    @(negedge clock);
    check1("bp_p1_granted", p1_req_ready, 1'b1);
    check1("bp_p0_done", p0_rsp_valid, 1'b0);
    next_cycle();
    p1_req_valid = 1'b0;
    repeat (2) next_cycle();
    @(negedge clock);
    check1("bp_p1_valid", p1_rsp_valid, 1'b1);
    check("bp_p1_data", p1_rsp_data, 32'd3);
    next_cycle();

    // Reset during EXEC discards the operation.
    reset_dut();
    drive_req(1'b0, 1'b1, 5'b00000, 32'd5, 32'd7);
    @(negedge clock);
    check1("rx_accept", p0_req_ready, 1'b1);
    next_cycle();
    p0_req_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    check("rx_exec_opcode", 32'(alu_opcode), 32'd0);
    next_cycle();
    @(negedge clock);
    check1("rx_valid", p0_rsp_valid, 1'b0);
    check("rx_opcode", 32'(alu_opcode), 32'(NOP));
    check("rx_alu_a", alu_a, 32'd0);
    check("rx_data", p0_rsp_data, 32'd0);
    check1("rx_busy", busy, 1'b0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check1("rx_no_rsp", p0_rsp_valid | p1_rsp_valid, 1'b0);
      next_cycle();
    end
    run_vec(vecs[0]);

    // Random traffic against a timing-level reference model.
    reset_dut();
    m_busy = 1'b0; m_lg = 1'b1; m_own = 1'b0; m_cnt = 0; m_lat = 0;
    m_data = '0; m_flag = 1'b0; m_err = 1'b0;
    acc[0] = 1'b0; acc[1] = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        logic v;
        v = (p == 1) ? p1_req_valid : p0_req_valid;
        if (acc[p]) drive_req(1'(p), 1'b0, 5'd0, 32'd0, 32'd0);
        else if (!v && $urandom_range(2) == 0)
          drive_req(1'(p), 1'b1, 5'($urandom), ($urandom_range(1) == 0) ? 32'($urandom_range(20)) : $urandom, $urandom);
        else if (v && $urandom_range(9) == 0)
          drive_req(1'(p), 1'b0, 5'd0, 32'd0, 32'd0);
        acc[p] = 1'b0;
      end
      p0_rsp_ready = 1'($urandom_range(1));
      p1_rsp_ready = 1'($urandom_range(1));
      @(negedge clock);
      check1("rnd_op_safe", alu_opcode == NOP || !is_illegal(alu_opcode), 1'b1);
      if (!m_busy) begin
        g0 = p0_req_valid && (!p1_req_valid || m_lg);
        g1 = p1_req_valid && (!p0_req_valid || !m_lg);
        check1("rnd_ready0", p0_req_ready, g0);
        check1("rnd_ready1", p1_req_ready, g1);
        check1("rnd_idle_valid", p0_rsp_valid | p1_rsp_valid, 1'b0);
        check1("rnd_idle_busy", busy, 1'b0);
        check("rnd_idle_opcode", 32'(alu_opcode), 32'(NOP));
        if (g0 || g1) begin
          logic [4:0] op;
          m_busy = 1'b1; m_own = g1; m_lg = g1; m_cnt = 0;
          op = g1 ? p1_op : p0_op;
          acc[g1] = 1'b1;
          if (is_illegal(op)) begin
            m_err = 1'b1; m_data = '0; m_flag = 1'b0; m_lat = 2;
          end else begin
            m_err = 1'b0; m_lat = 3;
            {m_flag, m_data} = g1 ? ula_f(op, p1_a, p1_b) : ula_f(op, p0_a, p0_b);
          end
        end
      end else begin
        m_cnt++;
        check1("rnd_busy_ready", p0_req_ready | p1_req_ready, 1'b0);
        check1("rnd_busy", busy, 1'b1);
        check1("rnd_valid_own", rsp_v(m_own), m_cnt >= m_lat);
        check1("rnd_valid_other", rsp_v(!m_own), 1'b0);
        if (m_cnt >= m_lat) begin
          check("rnd_data", rsp_d(m_own), m_data);
          check1("rnd_flag", rsp_f(m_own), m_flag);
          check1("rnd_err", rsp_e(m_own), m_err);
          if (m_own ? p1_rsp_ready : p0_rsp_ready) m_busy = 1'b0;
        end
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
